// File: rtl/fifo_reader.sv
// ============================================================================
// Module  : fifo_reader
// Purpose : FIFO consumer that pops on !empty, absorbs the one-cycle read
//           latency and re-issues words as a valid/ready stream via a 2-deep skid.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_reader #(
  parameter int DATA_WIDTH  = 12,
  parameter int COUNT_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   fifo_empty,
  input  logic                   fifo_error,
  input  logic [DATA_WIDTH-1:0]  fifo_data,
  output logic                   fifo_read_enable,
  output logic [DATA_WIDTH-1:0]  data_out,
  output logic                   valid_out,
  input  logic                   ready_in,
  output logic [1:0]             state,
  output logic [COUNT_WIDTH-1:0] word_count,
  output logic                   error
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACTIVE = 2'b01,
    DRAIN  = 2'b10
  } state_t;

  state_t                state_q;
  state_t                state_d;
  logic [DATA_WIDTH-1:0] skid_head;
  logic [DATA_WIDTH-1:0] skid_tail;
  logic [1:0]            occ;
  logic                  inflight;
  logic                  take;
  logic                  overflow;
  logic [2:0]            pending;

  assign state     = state_q;
  assign data_out  = skid_head;
  assign valid_out = (occ != 2'd0);
  assign take      = valid_out & ready_in;

  // Words already owned by the skid after this cycle, counting the one in flight.
  assign pending          = {1'b0, occ} + {2'b00, inflight} - {2'b00, take};
  assign fifo_read_enable = (state_q == ACTIVE) & ~fifo_empty & (pending < 3'd2);
  assign overflow         = inflight & ~take & (occ == 2'd2);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      skid_head  <= '0;
      skid_tail  <= '0;
      occ        <= 2'd0;
      inflight   <= 1'b0;
      word_count <= '0;
      error      <= 1'b0;
    end else begin
      state_q  <= state_d;
      inflight <= fifo_read_enable;
      if (take) begin
        word_count <= word_count + 1'b1;
      end
      if (fifo_error | overflow) begin
        error <= 1'b1;
      end
      case ({take, inflight})
        2'b01: begin
          if (occ == 2'd0) begin
            skid_head <= fifo_data;
            occ       <= 2'd1;
          end else if (occ == 2'd1) begin
            skid_tail <= fifo_data;
            occ       <= 2'd2;
          end
        end
        2'b10: begin
          skid_head <= skid_tail;
          occ       <= occ - 2'd1;
        end
        2'b11: begin
          // Simultaneous take and capture: occupancy holds, queue shifts by one.
          if (occ == 2'd2) begin
            skid_head <= skid_tail;
            skid_tail <= fifo_data;
          end else begin
            skid_head <= fifo_data;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (enable) state_d = ACTIVE;
      end
      ACTIVE: begin
        if (!enable) state_d = DRAIN;
      end
      DRAIN: begin
        if (enable) begin
          state_d = ACTIVE;
        end else if ((occ == 2'd0) && !inflight) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

`default_nettype wire
